step_sequencer: RTL and testbench

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer_if.sv | 22 ++
 rtl/step_sequencer.sv | 131 +++++++++++++
 tb/tb_step_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the time-pulse generator side and the step sequencer.
interface step_sequencer_if;
  logic       CP;
  logic [3:0] Sublevel;
  logic       RUN;
  logic       MODE;
  logic       CLR;
  logic [3:0] Step;
  logic       Wrap;
  logic [7:0] Cycles;
  logic [1:0] State;

  modport master (
    output CP, Sublevel, RUN, MODE, CLR,
    input  Step, Wrap, Cycles, State
  );

  modport slave (
    input  CP, Sublevel, RUN, MODE, CLR,
    output Step, Wrap, Cycles, State
  );
endinterface

// File: rtl/step_sequencer.sv
// Ramp/triangle step sequencer advanced by rising edges of CP, with hold,
// clear, per-period limit latching and a saturating period counter.
module step_sequencer (
  input  logic              CLK,
  input  logic              RST,
  step_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    HOLD = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] lim_q, lim_d;
  logic       mode_q, mode_d;
  logic       dn_q, dn_d;
  logic       wrap_q, wrap_d;
  logic [7:0] cycles_q, cycles_d;
  logic       cp_q;
  logic       cp_edge;
  logic       bump;
  logic       relatch;

  assign cp_edge = bus.CP & ~cp_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      step_q   <= '0;
      lim_q    <= '0;
      mode_q   <= 1'b0;
      dn_q     <= 1'b0;
      wrap_q   <= 1'b0;
      cycles_q <= '0;
      cp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      lim_q    <= lim_d;
      mode_q   <= mode_d;
      dn_q     <= dn_d;
      wrap_q   <= wrap_d;
      cycles_q <= cycles_d;
      cp_q     <= bus.CP;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    lim_d    = lim_q;
    mode_d   = mode_q;
    dn_d     = dn_q;
    wrap_d   = 1'b0;
    cycles_d = cycles_q;
    bump     = 1'b0;
    relatch  = 1'b0;

    if (bus.CLR) begin
      state_d  = IDLE;
      step_d   = '0;
      cycles_d = '0;
      dn_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          step_d = '0;
          if (bus.RUN) begin
            state_d = UP;
            relatch = 1'b1;
          end
        end
        UP: begin
          if (!bus.RUN) begin
            state_d = HOLD;
            dn_d    = 1'b0;
          end else if (cp_edge) begin
            if (step_q < lim_q) begin
              step_d = step_q + 4'd1;
            end else if (!mode_q || (lim_q <= 4'd1)) begin
              // A triangle with lim=1 peaks then lands straight on 0, so it
              // closes the period here instead of entering DOWN at step 0.
              step_d = '0;
              bump   = 1'b1;
            end else begin
              step_d  = lim_q - 4'd1;
              state_d = DOWN;
            end
          end
        end
        DOWN: begin
          if (!bus.RUN) begin
            state_d = HOLD;
            dn_d    = 1'b1;
          end else if (cp_edge) begin
            step_d = step_q - 4'd1;
            if (step_q == 4'd1) begin
              bump    = 1'b1;
              state_d = UP;
            end
          end
        end
        HOLD: begin
          if (bus.RUN) state_d = dn_q ? DOWN : UP;
        end
        default: state_d = IDLE;
      endcase
    end

    if (bump) begin
      wrap_d  = 1'b1;
      relatch = 1'b1;
      if (cycles_q != 8'hFF) cycles_d = cycles_q + 8'd1;
    end

    if (relatch) begin
      lim_d  = bus.Sublevel;
      mode_d = bus.MODE;
    end
  end

  assign bus.Step   = step_q;
  assign bus.Wrap   = wrap_q;
  assign bus.Cycles = cycles_q;
  assign bus.State  = state_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed and randomized checks of step_sequencer against a period-table reference model.
module tb_step_sequencer;

  logic CLK;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;

  step_sequencer_if bus();

  step_sequencer dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: phase 0=idle 1=running 2=held; pos indexes the period table.
  int m_phase, m_step, m_cycles, m_wrap, m_cpq, m_lim, m_mode, m_pos, m_dn;

  task automatic model_reset();
    m_phase = 0; m_step = 0; m_cycles = 0; m_wrap = 0; m_cpq = 0;
    m_lim = 0; m_mode = 0; m_pos = 0; m_dn = 0;
  endtask

  // k-th value of one period: ramp 1..L,0 ; triangle 1..L,L-1..0 ; L=0 -> 0
  function automatic int period_val(int k, int lim, int mode);
    if (k < lim) return k + 1;
    if (mode == 0 || lim == 0) return 0;
    return 2 * lim - 1 - k;
  endfunction

  task automatic model_step();
    int cpe;
    int k;
    int v;
    cpe = (bus.CP === 1'b1 && m_cpq == 0) ? 1 : 0;
    if (RST !== 1'b1) begin
      model_reset();
      return;
    end
    m_cpq  = (bus.CP === 1'b1) ? 1 : 0;
    m_wrap = 0;
    if (bus.CLR) begin
      m_phase = 0; m_step = 0; m_cycles = 0; m_pos = 0; m_dn = 0;
    end else begin
      case (m_phase)
        0: if (bus.RUN) begin
             m_phase = 1; m_lim = int'(bus.Sublevel); m_mode = int'(bus.MODE);
             m_pos = 0; m_dn = 0;
           end
        1: if (!bus.RUN) m_phase = 2;
           else if (cpe != 0) begin
             k = m_pos;
             v = period_val(k, m_lim, m_mode);
             m_pos++;
             m_step = v;
             if (v == 0) begin
               m_wrap = 1;
               if (m_cycles < 255) m_cycles++;
               m_lim = int'(bus.Sublevel); m_mode = int'(bus.MODE);
               m_pos = 0; m_dn = 0;
             end else begin
               m_dn = (m_mode != 0 && k >= m_lim) ? 1 : 0;
             end
           end
        default: if (bus.RUN) m_phase = 1;
      endcase
    end
  endtask

  function automatic int exp_state();
    if (m_phase == 0) return 0;
    if (m_phase == 2) return 3;
    return m_dn ? 2 : 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".Step"},   32'(bus.Step),   32'(m_step));
    chk({tag, ".Wrap"},   32'(bus.Wrap),   32'(m_wrap));
    chk({tag, ".Cycles"}, 32'(bus.Cycles), 32'(m_cycles));
    chk({tag, ".State"},  32'(bus.State),  32'(exp_state()));
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic cp_pulse(string tag);
    bus.CP = 1'b1; tick(tag);
    bus.CP = 1'b0; tick(tag);
  endtask

  task automatic clear(string tag);
    bus.CLR = 1'b1; tick(tag);
    bus.CLR = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    bus.CP = 1'b0; bus.Sublevel = '0; bus.RUN = 1'b0; bus.MODE = 1'b0; bus.CLR = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    tick("reset"); tick("reset");
    RST = 1'b1;
    tick("idle");

    // Ramp 0..7
    bus.Sublevel = 4'd7; bus.MODE = 1'b0; bus.RUN = 1'b1;
    tick("ramp_start");
    for (int i = 0; i < 8; i++) cp_pulse("ramp");
    chk("ramp_cycles", 32'(bus.Cycles), 32'd1);
    chk("ramp_step0",  32'(bus.Step),   32'd0);

    // Triangle 0..3..0, CP edge coincident with IDLE->UP ignored
    clear("tri_clr");
    bus.Sublevel = 4'd3; bus.MODE = 1'b1; bus.CP = 1'b1;
    tick("tri_start");
    bus.CP = 1'b0; tick("tri_start");
    chk("tri_ignored_edge", 32'(bus.Step), 32'd0);
    for (int i = 0; i < 6; i++) cp_pulse("tri");
    chk("tri_state_up", 32'(bus.State), 32'd1);
    chk("tri_cycles",   32'(bus.Cycles), 32'd1);

    // Limit change mid-period applies at next boundary
    clear("rel_clr");
    bus.Sublevel = 4'd7; bus.MODE = 1'b0;
    tick("rel_start");
    for (int i = 0; i < 4; i++) cp_pulse("rel_a");
    bus.Sublevel = 4'd3;
    for (int i = 0; i < 3; i++) cp_pulse("rel_b");
    chk("rel_reach7", 32'(bus.Step), 32'd7);
    cp_pulse("rel_wrap");
    for (int i = 0; i < 3; i++) cp_pulse("rel_c");
    chk("rel_peak3", 32'(bus.Step), 32'd3);
    cp_pulse("rel_wrap2");
    chk("rel_wrap2_step", 32'(bus.Step), 32'd0);

    // Hold in DOWN at step 5
    clear("hold_clr");
    bus.Sublevel = 4'd9; bus.MODE = 1'b1;
    tick("hold_start");
    for (int i = 0; i < 13; i++) cp_pulse("hold_run");
    chk("hold_pre_step", 32'(bus.Step), 32'd5);
    chk("hold_pre_down", 32'(bus.State), 32'd2);
    bus.RUN = 1'b0; bus.CP = 1'b1; tick("hold_enter");
    bus.CP = 1'b0; tick("hold_enter");
    for (int i = 0; i < 3; i++) cp_pulse("hold");
    chk("hold_step",  32'(bus.Step),  32'd5);
    chk("hold_state", 32'(bus.State), 32'd3);
    bus.RUN = 1'b1; tick("hold_exit");
    cp_pulse("hold_resume");
    chk("hold_resume_step", 32'(bus.Step), 32'd4);

    // lim=0: wrap on every edge, Cycles saturates, then CLR
    clear("sat_clr");
    bus.Sublevel = 4'd0; bus.MODE = 1'b0;
    tick("sat_start");
    for (int i = 0; i < 300; i++) begin
      bus.CP = 1'b1; tick("sat");
      chk("sat_wrap_each", 32'(bus.Wrap), 32'd1);
      bus.CP = 1'b0; tick("sat");
    end
    chk("sat_255", 32'(bus.Cycles), 32'd255);
    clear("sat_clear");
    chk("clr_cycles", 32'(bus.Cycles), 32'd0);
    chk("clr_state",  32'(bus.State),  32'd0);

    // Reset mid-run takes effect without a clock edge
    bus.Sublevel = 4'd9;
    tick("rst_start");
    for (int i = 0; i < 6; i++) cp_pulse("rst_run");
    chk("rst_pre_step", 32'(bus.Step), 32'd6);
    #3;
    RST = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    RST = 1'b1;
    tick("rst_exit");
    tick("rst_up");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.CP  = 1'($urandom_range(0, 1));
      bus.RUN = ($urandom_range(0, 9) != 0);
      bus.CLR = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.Sublevel = 4'($urandom_range(0, 15));
        bus.MODE     = 1'($urandom_range(0, 1));
      end
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
